debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_sync.sv | 130 +++++++++++++
 tb/tb_debounce_sync.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Switch/pin debouncer: multi-flop synchroniser followed by an IDLE/CHECK
// qualification FSM. Define DEBOUNCE_EDGE_EN to get registered rise/fall pulses.

module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clock,
    input  logic clearb,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic stable
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_e;

    // Last count value before the level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("debounce_sync: SYNC_STAGES must be 2..4");
        end
        if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W)) begin : g_bad_cycles
            $error("debounce_sync: DEBOUNCE_CYCLES must be 2..2^CNT_W");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   d_sync;

    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], d};
    assign d_sync = sync_q[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        unique case (state_q)
            ST_IDLE: begin
                if (d_sync != level_q) begin
                    state_d = ST_CHECK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CHECK: begin
                if (d_sync == level_q) begin
                    // Glitch shorter than the qualification window: drop it.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = d_sync;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign q      = level_q;
    assign stable = (state_q == ST_IDLE);

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    // Pulses are registered alongside level_q so they coincide with the new q.
    always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed scenarios plus random runs,
// compared every cycle against a run-length reference model.

module tb_debounce_sync;

    localparam int S  = 2;
    localparam int DC = 4;
    localparam int CW = 8;

    logic clock;
    logic clearb;
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic stable;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: d values still in flight through the synchroniser,
    // the accepted level, and the length of the current run of differing samples.
    bit dq[$];
    bit mq;
    int run;
    bit er;
    bit ef;

    debounce_sync #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CW)
    ) dut (
        .clock (clock),
        .clearb(clearb),
        .d     (d),
        .q     (q),
        .rise  (rise),
        .fall  (fall),
        .stable(stable)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        dq.delete();
        repeat (S) dq.push_back(1'b0);
        mq  = 1'b0;
        run = 0;
        er  = 1'b0;
        ef  = 1'b0;
    endtask

    // A level is accepted once DC consecutive synchronised samples differ from it.
    task automatic model_edge();
        bit sample;
        sample = dq.pop_front();
        dq.push_back(d);
        er = 1'b0;
        ef = 1'b0;
        if (sample != mq) begin
            run++;
            if (run == DC) begin
                mq  = sample;
                er  = sample;
                ef  = !sample;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic check_all(input string tag);
        bit exp_rise;
        bit exp_fall;
`ifdef DEBOUNCE_EDGE_EN
        exp_rise = er;
        exp_fall = ef;
`else
        exp_rise = 1'b0;
        exp_fall = 1'b0;
`endif
        check({tag, ".q"},      32'(q),      32'(mq));
        check({tag, ".rise"},   32'(rise),   32'(exp_rise));
        check({tag, ".fall"},   32'(fall),   32'(exp_fall));
        check({tag, ".stable"}, 32'(stable), 32'(run == 0));
        check({tag, ".excl"},   32'(rise & fall), 32'd0);
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic step(input bit dv, input string tag);
        @(negedge clock);
        d = dv;
        tick(tag);
    endtask

    initial begin
        int first_q;
        int first_unstable;
        int n_rise;
        int n_fall;
        bit v;
        int len;

        // Reset held with d high: outputs pinned at reset values.
        clearb = 1'b0;
        d      = 1'b1;
        model_reset();
        #1;
        check("rst.q",      32'(q),      32'd0);
        check("rst.rise",   32'(rise),   32'd0);
        check("rst.fall",   32'(fall),   32'd0);
        check("rst.stable", 32'(stable), 32'd1);
        #11;
        clearb = 1'b1;

        // Release with d held high: q rises on the 6th edge after release.
        first_q = 0;
        n_rise  = 0;
        for (int e = 1; e <= 10; e++) begin
            tick("rel");
            if (q === 1'b1 && first_q == 0) first_q = e;
            if (rise === 1'b1) n_rise++;
        end
        check("rel.q_edge", 32'(first_q), 32'd6);
`ifdef DEBOUNCE_EDGE_EN
        check("rel.n_rise", 32'(n_rise), 32'd1);
`else
        check("rel.n_rise", 32'(n_rise), 32'd0);
`endif

        // Falling level change from q=1.
        first_q = 0;
        n_rise  = 0;
        n_fall  = 0;
        for (int e = 1; e <= 10; e++) begin
            step(1'b0, "fall");
            if (q === 1'b0 && first_q == 0) first_q = e;
            if (rise === 1'b1) n_rise++;
            if (fall === 1'b1) n_fall++;
        end
        check("fall.q_edge", 32'(first_q), 32'd6);
        check("fall.n_rise", 32'(n_rise), 32'd0);
`ifdef DEBOUNCE_EDGE_EN
        check("fall.n_fall", 32'(n_fall), 32'd1);
`else
        check("fall.n_fall", 32'(n_fall), 32'd0);
`endif

        // Rising level change from q=0: stable drops on the 3rd edge.
        first_q        = 0;
        first_unstable = 0;
        n_rise         = 0;
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, "rise");
            if (q === 1'b1 && first_q == 0) first_q = e;
            if (stable === 1'b0 && first_unstable == 0) first_unstable = e;
            if (rise === 1'b1) n_rise++;
        end
        check("rise.q_edge",      32'(first_q),        32'd6);
        check("rise.stable_edge", 32'(first_unstable), 32'd3);
        check("rise.stable_end",  32'(stable),         32'd1);
`ifdef DEBOUNCE_EDGE_EN
        check("rise.n_rise", 32'(n_rise), 32'd1);
`else
        check("rise.n_rise", 32'(n_rise), 32'd0);
`endif

        // Back to q=0, then a two-cycle glitch high must be filtered.
        repeat (10) step(1'b0, "to0");
        n_rise = 0;
        step(1'b1, "glitch");
        if (rise === 1'b1) n_rise++;
        step(1'b1, "glitch");
        if (rise === 1'b1) n_rise++;
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, "glitch");
            if (rise === 1'b1) n_rise++;
        end
        check("glitch.q",      32'(q),      32'd0);
        check("glitch.n_rise", 32'(n_rise), 32'd0);
        check("glitch.stable", 32'(stable), 32'd1);

        // Back-to-back: d high 4 cycles then low; fall lands on edge 10.
        first_q = 0;
        for (int e = 1; e <= 14; e++) begin
            step((e <= 4) ? 1'b1 : 1'b0, "b2b");
            if (e > 6 && q === 1'b0 && first_q == 0) first_q = e;
        end
        check("b2b.fall_edge", 32'(first_q), 32'd10);

        // Pending fall (cnt=2) abandoned by a short asynchronous reset.
        repeat (10) step(1'b1, "pre");
        repeat (4) step(1'b0, "pend");
        check("pend.stable", 32'(stable), 32'd0);
        #1;
        clearb = 1'b0;
        #1;
        check("arst.q",      32'(q),      32'd0);
        check("arst.stable", 32'(stable), 32'd1);
        check("arst.rise",   32'(rise),   32'd0);
        check("arst.fall",   32'(fall),   32'd0);
        #1;
        clearb = 1'b1;
        model_reset();
        n_rise = 0;
        n_fall = 0;
        for (int e = 1; e <= 10; e++) begin
            step(1'b0, "post");
            if (rise === 1'b1) n_rise++;
            if (fall === 1'b1) n_fall++;
        end
        check("post.n_pulse", 32'(n_rise + n_fall), 32'd0);

        // Random runs of assorted lengths around the qualification window.
        for (int k = 0; k < 120; k++) begin
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            repeat (len) step(v, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
